// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register between two CPU stages.
// Captures a DATA_W-bit bus from upstream and presents it downstream one cycle
// later. It sustains one beat per cycle, supports a synchronous flush, and keeps
// a saturating counter of back-pressure stall cycles.
//
// Build option: define PIPE_SKID_EN to add a two-entry skid buffer. In that
// mode left_ready is registered, so right_ready has no combinational path to
// left_ready. With the macro undefined there is a single register and
// left_ready = right_ready | ~right_valid.
//
// Handshake: a beat moves on a side only in a cycle where valid and ready are
// both high (lfire / rfire). A valid beat and its data stay unchanged until
// the beat fires. Ready never waits for valid.
// dbg_state exposes occupancy: 2'b00 empty, 2'b01 one beat, 2'b11 two beats.
module pipe_stage_reg #(
    parameter int DATA_W = 166,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              left_valid,
    output logic              left_ready,
    input  logic [DATA_W-1:0] left_data,
    output logic              right_valid,
    input  logic              right_ready,
    output logic [DATA_W-1:0] right_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr,
    output logic [1:0]        dbg_state
);

    logic              lfire;
    logic              rfire;
    logic              m_valid;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign lfire       = left_valid & left_ready;
    assign rfire       = right_valid & right_ready;
    assign right_valid = m_valid;
    assign right_data  = m_data_q;
    assign stall_cnt   = stall_cnt_q;

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              s_valid;
    logic [DATA_W-1:0] s_data_q;
    logic [DATA_W-1:0] s_data_d;

    // Occupancy comes straight from the state flop, so left_ready is registered.
    assign m_valid    = (state_q != ST_EMPTY);
    assign s_valid    = (state_q == ST_TWO);
    assign left_ready = ~s_valid;
    assign dbg_state  = state_q;

    // State, main and skid registers; reset clears the data so right_data reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    // Next state: fill main first, overflow into skid, refill main from skid.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (lfire) begin
                    state_d  = ST_ONE;
                    m_data_d = left_data;
                end
            end
            ST_ONE: begin
                if (lfire && rfire) begin
                    m_data_d = left_data;
                end else if (lfire) begin
                    state_d  = ST_TWO;
                    s_data_d = left_data;
                end else if (rfire) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (rfire) begin
                    state_d  = ST_ONE;
                    m_data_d = s_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops every held and incoming beat; the data registers keep their contents.
        if (flush) begin
            state_d  = ST_EMPTY;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
        end
    end
`else
    logic m_valid_q;
    logic m_valid_d;

    // Ready passes through combinationally: accept when the slot drains or is empty.
    assign m_valid    = m_valid_q;
    assign left_ready = right_ready | ~m_valid_q;
    assign dbg_state  = {1'b0, m_valid_q};

    // Single main register; reset clears the data so right_data reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Load on lfire, empty on rfire without a replacement, and drop everything on flush.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (lfire) begin
            m_valid_d = 1'b1;
            m_data_d  = left_data;
        end else if (rfire) begin
            m_valid_d = 1'b0;
        end
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = m_data_q;
        end
    end
`endif

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Count cycles where a held beat is refused downstream; clear wins; never wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (right_valid && !right_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

endmodule
